// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the native memory bus: request payload, master index and
// arbiter state encoding. The core's memory interface uses the same request struct.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic master_idx_t;

  typedef struct packed {
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

  // A tie goes to the master that did not own the bus last.
  function automatic master_idx_t rr_pick(input logic v0, input logic v1,
                                          input master_idx_t last);
    if (v0 && v1) return ~last;
    else if (v1)  return 1'b1;
    else          return 1'b0;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One memory-bus link: request payload travelling downstream, completion
// pulse and read data travelling back.
interface mem_bus_if;
  import mem_bus_pkg::*;

  // valid rises with req and both hold until the cycle after ready is sampled;
  // ready is a single-cycle completion pulse and rdata is meaningful only with it.
  logic              valid;
  bus_req_t          req;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, req, input ready, rdata);
  modport slave  (input valid, req, output ready, rdata);

endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the budget runs out. TIMEOUT_CYCLES of 0 disarms it.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic             expire,
  output logic [CNT_W-1:0] count
);

  localparam bit ARMED = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TERM =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  // Counting stops at the terminal value, so the counter never wraps.
  assign expire = ARMED && enable && (count_q == TERM);
  assign count  = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (ARMED && enable && !expire) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready memory bus, with a
// per-transaction watchdog that answers a stalled master with a synthetic fault.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_if.slave         m0,
  mem_bus_if.slave         m1,
  mem_bus_if.master        mem,
  output logic             m0_fault,
  output logic             m1_fault,
  output master_idx_t      grant,
  output arb_state_t       state,
  output logic [CNT_W-1:0] wd_count
);

  arb_state_t             state_q, state_n;
  logic                   mem_valid_q, mem_valid_n;
  bus_req_t               mem_req_q, mem_req_n;
  master_idx_t            grant_q, grant_n;
  master_idx_t            last_q, last_n;
  master_idx_t            pick;
  logic [1:0]             rsp_ready_q, rsp_ready_n;
  logic [1:0]             rsp_fault_q, rsp_fault_n;
  logic [1:0][DATA_W-1:0] rsp_rdata_q, rsp_rdata_n;
  logic                   wd_clear, wd_enable, wd_expire;

  assign pick      = rr_pick(m0.valid, m1.valid, last_q);
  assign wd_enable = (state_q == BUSY) && !mem.ready;

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire),
    .count  (wd_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_req_q   <= '0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      rsp_ready_q <= '0;
      rsp_fault_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_n;
      mem_valid_q <= mem_valid_n;
      mem_req_q   <= mem_req_n;
      grant_q     <= grant_n;
      last_q      <= last_n;
      rsp_ready_q <= rsp_ready_n;
      rsp_fault_q <= rsp_fault_n;
      rsp_rdata_q <= rsp_rdata_n;
    end
  end

  // Response signals default to zero every cycle, so they pulse for RESP only.
  always_comb begin
    state_n     = state_q;
    mem_valid_n = mem_valid_q;
    mem_req_n   = mem_req_q;
    grant_n     = grant_q;
    last_n      = last_q;
    rsp_ready_n = '0;
    rsp_fault_n = '0;
    rsp_rdata_n = '0;
    wd_clear    = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0.valid || m1.valid) begin
          mem_req_n   = pick ? m1.req : m0.req;
          mem_valid_n = 1'b1;
          grant_n     = pick;
          last_n      = pick;
          wd_clear    = 1'b1;
          state_n     = BUSY;
        end
      end
      BUSY: begin
        if (mem.ready) begin
          mem_valid_n          = 1'b0;
          rsp_ready_n[grant_q] = 1'b1;
          rsp_rdata_n[grant_q] = mem.rdata;
          state_n              = RESP;
        end else if (wd_expire) begin
          mem_valid_n          = 1'b0;
          rsp_ready_n[grant_q] = 1'b1;
          rsp_fault_n[grant_q] = 1'b1;
          state_n              = RESP;
        end
      end
      // RESP never grants: the finishing master drops valid during it.
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign mem.valid = mem_valid_q;
  assign mem.req   = mem_req_q;
  assign m0.ready  = rsp_ready_q[0];
  assign m0.rdata  = rsp_rdata_q[0];
  assign m1.ready  = rsp_ready_q[1];
  assign m1.rdata  = rsp_rdata_q[1];
  assign m0_fault  = rsp_fault_q[0];
  assign m1_fault  = rsp_fault_q[1];
  assign grant     = grant_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized two-master
// traffic checked against a transaction-level arbitration/response model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int TO    = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             m0_fault, m1_fault;
  master_idx_t      grant;
  arb_state_t       state;
  logic [CNT_W-1:0] wd_count;

  mem_bus_if m0_bus ();
  mem_bus_if m1_bus ();
  mem_bus_if mem_bus ();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0       (m0_bus),
    .m1       (m1_bus),
    .mem      (mem_bus),
    .m0_fault (m0_fault),
    .m1_fault (m1_fault),
    .grant    (grant),
    .state    (state),
    .wd_count (wd_count)
  );

  // ---------------- clock / global bound ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp0_q[$];
  logic [32:0] exp1_q[$];
  int          grant_log[$];
  bus_req_t    cur_req[2];
  logic        snap_v[2];
  logic        model_last;
  bit          done_m[2];

  // Which masters were requesting at the most recent rising edge.
  always @(posedge clk) begin
    snap_v[0] <= m0_bus.valid;
    snap_v[1] <= m1_bus.valid;
  end

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input int idx, input logic v, input bus_req_t r);
    if (idx == 1) begin
      m1_bus.valid = v;
      m1_bus.req   = r;
    end else begin
      m0_bus.valid = v;
      m0_bus.req   = r;
    end
  endtask

  task automatic issue(input int idx, input bus_req_t r);
    cur_req[idx] = r;
    drive(idx, 1'b1, r);
  endtask

  function automatic logic rdy(input int idx);
    return (idx == 1) ? m1_bus.ready : m0_bus.ready;
  endfunction

  function automatic bus_req_t make_req(input int idx, input bit fixed);
    bus_req_t r;
    if (fixed) begin
      r.instr = 1'b0;
      r.addr  = (idx == 1) ? 32'h0000_0004 : 32'h0000_0200;
      r.wdata = $urandom;
      r.wstrb = (idx == 1) ? 4'hF : 4'h0;
    end else begin
      r.wstrb = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0;
      r.instr = (r.wstrb == 4'h0) ? 1'($urandom) : 1'b0;
      r.addr  = $urandom;
      r.wdata = $urandom;
    end
    return r;
  endfunction

  task automatic push_exp(input int idx, input logic [32:0] v);
    if (idx == 1) exp1_q.push_back(v);
    else          exp0_q.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    mem_bus.ready = 1'b0;
    mem_bus.rdata = '0;
    model_last    = 1'b1;
    exp0_q.delete();
    exp1_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- slave model + arbitration reference ----------------
  // Called on the first negedge of a downstream request. Decides who should
  // own the bus from the requesters at the grant edge, then answers after
  // `lat` cycles (lat >= TO means the slave stays silent).
  task automatic serve(input int lat, input logic [31:0] data);
    int       win;
    int       k;
    logic     hold_bad;
    bus_req_t want;
    if (snap_v[0] && snap_v[1]) win = (model_last == 1'b1) ? 0 : 1;
    else                        win = snap_v[1] ? 1 : 0;
    model_last = (win == 1);
    grant_log.push_back(win);
    want = cur_req[win];
    check_val("grant", grant, win);
    check_val("mem_req", mem_bus.req, want);
    hold_bad = 1'b0;
    if (lat < TO) begin
      for (k = 0; k < lat; k++) begin
        @(negedge clk);
        if (!mem_bus.valid || mem_bus.req !== want) hold_bad = 1'b1;
      end
      mem_bus.ready = 1'b1;
      mem_bus.rdata = data;
      push_exp(win, {1'b0, data});
      @(negedge clk);
      mem_bus.ready = 1'b0;
      mem_bus.rdata = $urandom;
      check_val("mem_drop", mem_bus.valid, 1'b0);
    end else begin
      push_exp(win, {1'b1, 32'h0});
      k = 1;
      while (k < TO + 4) begin
        @(negedge clk);
        if (!mem_bus.valid) break;
        if (mem_bus.req !== want) hold_bad = 1'b1;
        k++;
      end
      check_val("timeout_len", k, TO);
    end
    check_val("mem_hold", hold_bad, 1'b0);
  endtask

  // Called in the cycle a master's ready is high.
  task automatic take_rsp(input int idx);
    logic [32:0] got;
    logic [32:0] e;
    int          sz;
    got = (idx == 1) ? {m1_fault, m1_bus.rdata} : {m0_fault, m0_bus.rdata};
    sz  = (idx == 1) ? exp1_q.size() : exp0_q.size();
    check_val("other_ready", rdy(1 - idx), 1'b0);
    if (sz == 0) begin
      check_val("unexpected_rsp", sz, 1);
    end else begin
      if (idx == 1) e = exp1_q.pop_front();
      else          e = exp0_q.pop_front();
      check_val((idx == 1) ? "m1_rsp" : "m0_rsp", got, e);
    end
  endtask

  task automatic finish_txn(input int idx, input int lat, input logic [31:0] data);
    int w = 0;
    while (!mem_bus.valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_val("valid_seen", mem_bus.valid, 1'b1);
    if (mem_bus.valid) begin
      serve(lat, data);
      check_val("ready_seen", rdy(idx), 1'b1);
      take_rsp(idx);
    end
    @(posedge clk); #1;
    drive(idx, 1'b0, cur_req[idx]);
  endtask

  // ---------------- concurrent traffic processes ----------------
  task automatic master_run(input int idx, input int n, input int max_gap, input bit fixed);
    int waited;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        @(posedge clk); #1;
      end
      issue(idx, make_req(idx, fixed));
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!rdy(idx) && waited < 300);
      if (!rdy(idx)) check_val("master_wait", waited, 0);
      else           take_rsp(idx);
      @(posedge clk); #1;
      drive(idx, 1'b0, cur_req[idx]);
    end
    done_m[idx] = 1'b1;
  endtask

  task automatic slave_loop(input int max_lat, input int to_pct);
    int cyc = 0;
    int lat;
    while (!(done_m[0] && done_m[1]) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (mem_bus.valid) begin
        if ($urandom_range(99, 0) < to_pct) lat = TO + 2;
        else                                lat = $urandom_range(max_lat, 0);
        serve(lat, $urandom);
      end
    end
    if (cyc >= 20000) check_val("slave_budget", cyc, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    // reset asserted for two edges already; values checked before release
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_state", state, IDLE);
    check_val("rst_mem", {mem_bus.valid, mem_bus.req}, '0);
    check_val("rst_m_out", {m0_bus.ready, m0_bus.rdata, m0_fault, m1_bus.ready, m1_bus.rdata, m1_fault}, '0);
    check_val("rst_grant", grant, 1'b0);
    check_val("rst_wd", wd_count, '0);
    reset = 1'b1;

    // m0 read, slave answers in the third busy cycle
    @(posedge clk); #1;
    issue(0, '{instr: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, wstrb: 4'h0});
    @(negedge clk);
    check_val("lat_before", mem_bus.valid, 1'b0);
    @(negedge clk);
    check_val("lat_after", {mem_bus.valid, mem_bus.req.addr}, {1'b1, 32'h0000_0100});
    finish_txn(0, 2, 32'hDEAD_BEEF);
    @(negedge clk);
    check_val("t1_idle", {state, m0_bus.ready, m1_bus.ready}, {IDLE, 2'b00});

    // both masters request from reset and re-request at once: strict alternation
    do_reset();
    @(posedge clk); #1;
    grant_log.delete();
    done_m[0] = 1'b0;
    done_m[1] = 1'b0;
    fork
      master_run(0, 3, 0, 1'b1);
      master_run(1, 3, 0, 1'b1);
      slave_loop(3, 0);
    join
    check_val("fair_len", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size(); i++) check_val("fair_seq", grant_log[i], i % 2);

    // m1 write with a silent slave: synthetic fault after TO cycles
    @(posedge clk); #1;
    issue(1, '{instr: 1'b0, addr: 32'h0000_0040, wdata: 32'hA5A5_5A5A, wstrb: 4'hF});
    finish_txn(1, TO + 5, 32'h0);
    @(negedge clk);
    check_val("to_idle", {state, m1_bus.ready, m1_fault}, {IDLE, 2'b00});

    // mem_ready lands on the terminal watchdog cycle: completion wins
    @(posedge clk); #1;
    issue(0, '{instr: 1'b1, addr: 32'h0000_0500, wdata: 32'h0, wstrb: 4'h0});
    finish_txn(0, TO - 1, 32'h1234_5678);

    // asynchronous reset in the middle of a busy transaction
    @(posedge clk); #1;
    issue(0, '{instr: 1'b0, addr: 32'h0000_0300, wdata: 32'h0, wstrb: 4'h0});
    @(negedge clk);
    @(negedge clk);
    check_val("mid_busy", state, BUSY);
    #2 reset = 1'b0;
    #1;
    check_val("async_rst", {state, mem_bus.valid, mem_bus.req, grant, m0_bus.ready, m0_fault}, {IDLE, 1'b0, 69'h0, 1'b0, 1'b0, 1'b0});
    issue(1, '{instr: 1'b0, addr: 32'h0000_0004, wdata: 32'hCAFE_F00D, wstrb: 4'hF});
    exp0_q.delete();
    exp1_q.delete();
    @(negedge clk);
    reset      = 1'b1;
    model_last = 1'b1;
    finish_txn(0, 1, 32'h0BAD_CAFE);
    finish_txn(1, 0, 32'h7777_0000);

    // spurious mem_ready while idle
    @(negedge clk);
    mem_bus.ready = 1'b1;
    mem_bus.rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_bus.ready = 1'b0;
    check_val("spur_idle", {state, mem_bus.valid, m0_bus.ready, m1_bus.ready}, {IDLE, 3'b000});
    @(negedge clk);
    check_val("spur_after", {state, m0_bus.ready, m1_bus.ready, m0_fault, m1_fault}, {IDLE, 4'b0000});

    // randomized two-master traffic with occasional silent slave
    @(posedge clk); #1;
    done_m[0] = 1'b0;
    done_m[1] = 1'b0;
    fork
      master_run(0, 25, 4, 1'b0);
      master_run(1, 25, 4, 1'b0);
      slave_loop(4, 15);
    join

    check_val("exp0_empty", exp0_q.size(), 0);
    check_val("exp1_empty", exp1_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
